// File: rtl/mips_mc_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared datapath with a request/ready memory handshake. The state port exposes the FSM
// encoding: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXECUTE, 7 ALUWB,
// 8 BRANCH, 9 ADDIEX, 10 ADDIWB, 11 JUMP.
module mips_mc_control (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_we,
    output logic       pc_we,
    output logic [1:0] pc_src,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [2:0] alu_sel,
    output logic       reg_we,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    state_t state_q;
    state_t state_d;

    // Ungated enables; the reset gate below keeps them low while reset_n is asserted.
    logic mem_req_c;
    logic mem_we_c;
    logic ir_we_c;
    logic pc_we_c;
    logic reg_we_c;
    logic illegal_c;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d    = FETCH;
        mem_req_c  = 1'b0;
        mem_we_c   = 1'b0;
        ir_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        reg_we_c   = 1'b0;
        illegal_c  = 1'b0;
        iord       = 1'b0;
        pc_src     = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_sel    = 3'b000;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        case (state_q)
            FETCH: begin
                mem_req_c = 1'b1;
                alu_src_b = 2'b01;
                alu_sel   = 3'b010;
                ir_we_c   = mem_ready;
                pc_we_c   = mem_ready;
                state_d   = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                // Speculatively compute the branch target into ALU-out.
                alu_src_b = 2'b11;
                alu_sel   = 3'b010;
                case (opcode)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        state_d   = FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_sel   = 3'b010;
                if (opcode == OP_LW) begin
                    state_d = MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = MEMWR;
                end else begin
                    state_d = FETCH;
                end
            end
            MEMRD: begin
                mem_req_c = 1'b1;
                iord      = 1'b1;
                state_d   = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                reg_we_c   = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem_req_c = 1'b1;
                mem_we_c  = 1'b1;
                iord      = 1'b1;
                state_d   = mem_ready ? FETCH : MEMWR;
            end
            EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b00;
                case (funct)
                    6'b100000: alu_sel = 3'b010;
                    6'b100010: alu_sel = 3'b110;
                    6'b100100: alu_sel = 3'b000;
                    6'b100101: alu_sel = 3'b001;
                    6'b101010: alu_sel = 3'b111;
                    default: begin
                        alu_sel   = 3'b010;
                        illegal_c = 1'b1;
                    end
                endcase
                state_d = ALUWB;
            end
            ALUWB: begin
                reg_we_c = 1'b1;
                reg_dst  = 1'b1;
                state_d  = FETCH;
            end
            BRANCH: begin
                alu_src_a = 1'b1;
                alu_sel   = 3'b110;
                pc_src    = 2'b01;
                pc_we_c   = zero;
                state_d   = FETCH;
            end
            ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_sel   = 3'b010;
                state_d   = ADDIWB;
            end
            ADDIWB: begin
                reg_we_c = 1'b1;
                state_d  = FETCH;
            end
            JUMP: begin
                pc_src  = 2'b10;
                pc_we_c = 1'b1;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    assign mem_req = reset_n & mem_req_c;
    assign mem_we  = reset_n & mem_we_c;
    assign ir_we   = reset_n & ir_we_c;
    assign pc_we   = reset_n & pc_we_c;
    assign reg_we  = reset_n & reg_we_c;
    assign illegal = reset_n & illegal_c;

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: a per-instruction step-list model predicts every output on
// every cycle, with directed instruction scenarios and randomized traffic.
module tb_mips_mc_control;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [5:0] opcode = 6'd0;
    logic [5:0] funct = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_we, pc_we;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_sel;
    logic       reg_we, reg_dst, mem_to_reg, illegal;
    logic [3:0] state;

    mips_mc_control dut (
        .clock(clock), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .zero(zero), .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_sel(alu_sel),
        .reg_we(reg_we), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .illegal(illegal), .state(state)
    );

    // clock / reset
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // Step names as exposed on the state port.
    localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MW = 5;
    localparam int EX = 6, AWB = 7, BR = 8, AE = 9, AW = 10, J = 11;

    localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, mem_we, iord, ir_we, pc_we;
        logic [1:0] pc_src;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_sel;
        logic       reg_we, reg_dst, mem_to_reg, illegal;
    } obs_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   seq[$];
    int   pos = 0;
    bit   done_flag = 1'b0;
    obs_t log_q[$];
    obs_t cur;
    logic [20:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Step list an instruction walks through, derived from its opcode.
    function automatic void build_seq(input logic [5:0] op);
        seq.delete();
        seq.push_back(F);
        seq.push_back(D);
        case (op)
            OP_LW:   begin seq.push_back(MA); seq.push_back(MR); seq.push_back(MWB); end
            OP_SW:   begin seq.push_back(MA); seq.push_back(MW); end
            OP_R:    begin seq.push_back(EX); seq.push_back(AWB); end
            OP_BEQ:  seq.push_back(BR);
            OP_ADDI: begin seq.push_back(AE); seq.push_back(AW); end
            OP_J:    seq.push_back(J);
            default: ;
        endcase
    endfunction

    function automatic bit is_mem(input int s);
        return (s == F) || (s == MR) || (s == MW);
    endfunction

    function automatic bit op_ok(input logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

    function automatic obs_t exp_out(input int s, input bit rst, input logic rdy, input logic z);
        obs_t e;
        e = '0;
        if (rst) begin
            e.alu_src_b = 2'b01;
            e.alu_sel   = 3'b010;
            return e;
        end
        e.st = 4'(s);
        case (s)
            F:   begin e.mem_req = 1; e.alu_src_b = 2'b01; e.alu_sel = 3'b010; e.ir_we = rdy; e.pc_we = rdy; end
            D:   begin e.alu_src_b = 2'b11; e.alu_sel = 3'b010; e.illegal = !op_ok(opcode); end
            MA:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_sel = 3'b010; end
            MR:  begin e.mem_req = 1; e.iord = 1; end
            MWB: begin e.reg_we = 1; e.mem_to_reg = 1; end
            MW:  begin e.mem_req = 1; e.mem_we = 1; e.iord = 1; end
            EX: begin
                e.alu_src_a = 1;
                case (funct)
                    6'd32: e.alu_sel = 3'b010;
                    6'd34: e.alu_sel = 3'b110;
                    6'd36: e.alu_sel = 3'b000;
                    6'd37: e.alu_sel = 3'b001;
                    6'd42: e.alu_sel = 3'b111;
                    default: begin e.alu_sel = 3'b010; e.illegal = 1; end
                endcase
            end
            AWB: begin e.reg_we = 1; e.reg_dst = 1; end
            BR:  begin e.alu_src_a = 1; e.alu_sel = 3'b110; e.pc_src = 2'b01; e.pc_we = z; end
            AE:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; e.alu_sel = 3'b010; end
            AW:  e.reg_we = 1;
            J:   begin e.pc_src = 2'b10; e.pc_we = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.st = state; o.mem_req = mem_req; o.mem_we = mem_we; o.iord = iord;
        o.ir_we = ir_we; o.pc_we = pc_we; o.pc_src = pc_src; o.alu_src_a = alu_src_a;
        o.alu_src_b = alu_src_b; o.alu_sel = alu_sel; o.reg_we = reg_we;
        o.reg_dst = reg_dst; o.mem_to_reg = mem_to_reg; o.illegal = illegal;
        return o;
    endfunction

    // driver: one clock cycle, compared against the model, then the model advances.
    task automatic run_cycle(input logic rst_v, input logic rdy, input logic z);
        int s;
        @(negedge clock);
        reset_n = rst_v; mem_ready = rdy; zero = z;
        #2;
        if (!reset_n) pos = 0;
        s = seq[pos];
        exp_q.push_back(exp_out(s, !reset_n, rdy, z));
        cur = sample();
        log_q.push_back(cur);
        check("cycle_outputs", 32'(cur), 32'(exp_q.pop_front()));
        @(posedge clock);
        #1;
        if (reset_n) begin
            if (!(is_mem(s) && !rdy)) pos++;
            if (pos >= seq.size()) begin
                done_flag = 1'b1;
                pos = 0;
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw,
                             input int mw, input logic z, output int cycles);
        int s, prev, waited, lim;
        logic rdy;
        opcode = op; funct = fn;
        build_seq(op);
        pos = 0; done_flag = 1'b0; log_q.delete();
        cycles = 0; waited = 0; prev = -1;
        while (!done_flag && cycles < 40) begin
            s = seq[pos];
            if (s != prev) waited = 0;
            prev = s;
            if (is_mem(s)) begin
                lim = (s == F) ? fw : mw;
                rdy = (waited < lim) ? 1'b0 : 1'b1;
                waited++;
            end else begin
                rdy = 1'($urandom_range(0, 1));
            end
            run_cycle(1'b1, rdy, z);
            cycles++;
        end
        check("instr_completes", 32'(done_flag), 32'd1);
    endtask

    initial begin
        int cyc, cnt, stseq;
        logic [5:0] fns[5];
        logic [2:0] sels[5];
        logic [5:0] ops[6];
        logic [5:0] op, fn;
        fns  = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
        sels = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
        ops  = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
        build_seq(OP_LW);

        // reset for 3 cycles
        for (int i = 0; i < 3; i++) begin
            run_cycle(1'b0, 1'b1, 1'b1);
            check("reset_enables", 32'({cur.mem_req, cur.mem_we, cur.ir_we, cur.pc_we, cur.reg_we, cur.illegal}), 32'd0);
            check("reset_selects", 32'({cur.st, cur.alu_sel, cur.alu_src_b}), 32'({4'd0, 3'b010, 2'b01}));
        end

        // lw with memory always ready
        run_instr(OP_LW, 6'd0, 0, 0, 1'b0, cyc);
        check("lw_cycles", 32'(cyc), 32'd5);
        stseq = 0;
        cnt = 0;
        foreach (log_q[i]) begin
            stseq = (stseq << 4) | int'(log_q[i].st);
            cnt += int'(log_q[i].reg_we);
        end
        check("lw_states", 32'(stseq), 32'h01234);
        check("lw_reg_we_count", 32'(cnt), 32'd1);
        check("lw_wb", 32'({log_q[4].reg_we, log_q[4].mem_to_reg}), 32'b11);

        // R-type funct sweep
        foreach (fns[i]) begin
            run_instr(OP_R, fns[i], 0, 0, 1'b0, cyc);
            check("rtype_alu_sel", 32'(log_q[2].alu_sel), 32'(sels[i]));
            check("rtype_cycles", 32'(cyc), 32'd4);
        end
        run_instr(OP_R, 6'd0, 0, 0, 1'b0, cyc);
        check("bad_funct_exec", 32'({log_q[2].illegal, log_q[2].alu_sel}), 32'b1010);
        check("bad_funct_aluwb", 32'({log_q[3].st, log_q[3].reg_dst, log_q[3].illegal}), 32'({4'd7, 1'b1, 1'b0}));

        // beq taken and not taken
        run_instr(OP_BEQ, 6'd0, 0, 0, 1'b1, cyc);
        check("beq_taken", 32'({log_q[2].pc_we, log_q[2].pc_src}), 32'b101);
        check("beq_cycles", 32'(cyc), 32'd3);
        run_instr(OP_BEQ, 6'd0, 0, 0, 1'b0, cyc);
        check("beq_not_taken", 32'(log_q[2].pc_we), 32'd0);

        // sw with wait states
        run_instr(OP_SW, 6'd0, 2, 3, 1'b0, cyc);
        check("sw_wait_cycles", 32'(cyc), 32'd9);
        cnt = 0;
        foreach (log_q[i]) cnt += int'(log_q[i].ir_we);
        check("sw_ir_we_count", 32'(cnt), 32'd1);
        check("sw_ir_we_cycle", 32'(log_q[2].ir_we), 32'd1);
        cnt = 0;
        for (int i = 5; i < 9; i++) cnt += int'(log_q[i].mem_req & log_q[i].iord & log_q[i].mem_we);
        check("sw_memwr_stable", 32'(cnt), 32'd4);

        run_instr(OP_ADDI, 6'd0, 0, 0, 1'b0, cyc);
        check("addi_cycles", 32'(cyc), 32'd4);
        run_instr(OP_J, 6'd0, 0, 0, 1'b0, cyc);
        check("j_cycles", 32'(cyc), 32'd3);
        check("j_pc", 32'({log_q[2].pc_we, log_q[2].pc_src}), 32'b110);

        // illegal opcode
        run_instr(6'b111111, 6'd0, 0, 0, 1'b0, cyc);
        check("illegal_op_cycles", 32'(cyc), 32'd2);
        check("illegal_op_pulse", 32'(log_q[1].illegal), 32'd1);

        // async reset in the middle of MEMRD
        opcode = OP_LW; build_seq(OP_LW); pos = 0; done_flag = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 1'b0);
        run_cycle(1'b1, 1'b0, 1'b0);
        check("memrd_before_reset", 32'({cur.st, cur.mem_req}), 32'({4'd3, 1'b1}));
        run_cycle(1'b0, 1'b1, 1'b0);
        check("mid_reset_state", 32'({cur.st, cur.mem_req, cur.iord}), 32'({4'd0, 1'b0, 1'b0}));
        run_cycle(1'b0, 1'b1, 1'b0);

        // randomized traffic
        for (int n = 0; n < 300; n++) begin
            op = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : ops[$urandom_range(0, 5)];
            fn = ($urandom_range(0, 4) == 0) ? 6'($urandom_range(0, 63)) : fns[$urandom_range(0, 4)];
            run_instr(op, fn, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)), cyc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_mc_control.md
# mips_mc_control

Multicycle control unit that drives the shared MIPS datapath (register file, ALU, muxes, PC and instruction registers) and talks to a single unified memory through a request/ready handshake. The datapath blocks decode nothing themselves. This block turns the IR opcode/funct fields and the ALU `zero` flag into the per-cycle enables and selects, including the 3-bit ALU `sel` code.

## Interface
- No parameters.
- `clock` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous active-low reset.
- `opcode` in 6: IR[31:26], valid from DECODE onward.
- `funct` in 6: IR[5:0].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_we` out 1: memory write, qualified by `mem_req`.
- `iord` out 1: address mux select; 0 selects PC, 1 selects ALU-out.
- `ir_we` out 1: instruction register load.
- `pc_we` out 1: PC load.
- `pc_src` out 2: PC source; 00 selects ALU result, 01 selects ALU-out, 10 selects jump target.
- `alu_src_a` out 1: 0 selects PC, 1 selects register A.
- `alu_src_b` out 2: 00 selects B, 01 selects constant 4, 10 selects sign-extended immediate, 11 selects sign-extended immediate shifted left 2.
- `alu_sel` out 3: ALU code; 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `reg_we` out 1: register file write.
- `reg_dst` out 1: 0 selects rt, 1 selects rd.
- `mem_to_reg` out 1: 0 selects ALU-out, 1 selects memory data.
- `illegal` out 1: one-cycle pulse on an unsupported opcode or funct.

## Operation
- 4-bit registered state.
- Outputs are decoded combinationally from state, except:
  - the `pc_we` branch term;
  - the handshake-gated enables;
  - `alu_sel` in EXECUTE, which comes from `funct`.
- Every output not listed for a state is 0.
- Supported opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, addi 001000, j 000010.
- States and transitions:
  - FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_sel`=010, `pc_src`=00. `ir_we` and `pc_we` equal `mem_ready`. Moves to DECODE when `mem_ready`=1; otherwise stays in FETCH.
  - DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_sel`=010 (branch target into ALU-out). Moves by opcode: lw/sw go to MEMADR, R-type to EXECUTE, beq to BRANCH, addi to ADDIEX, j to JUMP. Any other opcode goes to FETCH with `illegal`=1.
  - MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_sel`=010. Moves to MEMRD for lw, MEMWR for sw.
  - MEMRD: `mem_req`=1, `iord`=1. Moves to MEMWB on `mem_ready`; otherwise holds.
  - MEMWB: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=1. Moves to FETCH.
  - MEMWR: `mem_req`=1, `mem_we`=1, `iord`=1. Moves to FETCH on `mem_ready`; otherwise holds.
  - EXECUTE: `alu_src_a`=1, `alu_src_b`=00. `alu_sel` is decoded from `funct`:
    - funct 100000 (add) → 010
    - funct 100010 (sub) → 110
    - funct 100100 (and) → 000
    - funct 100101 (or) → 001
    - funct 101010 (slt) → 111
    - any other funct → 010 with `illegal`=1 for this cycle; the instruction still completes.
    - Moves to ALUWB.
  - ALUWB: `reg_we`=1, `reg_dst`=1, `mem_to_reg`=0. Moves to FETCH.
  - BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_sel`=110, `pc_src`=01, `pc_we`=`zero`. Moves to FETCH.
  - ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_sel`=010. Moves to ADDIWB.
  - ADDIWB: `reg_we`=1, `reg_dst`=0, `mem_to_reg`=0. Moves to FETCH.
  - JUMP: `pc_src`=10, `pc_we`=1. Moves to FETCH.
- Unused state encodings go to FETCH on the next edge. No enables are asserted in an unused state.

## Timing
- Reset behaviour:
  - `reset_n`=0 forces state to FETCH immediately, asynchronously.
  - While `reset_n` is low, `mem_req`, `mem_we`, `ir_we`, `pc_we`, `reg_we` and `illegal` are forced to 0.
  - The selects hold their FETCH values during reset: `alu_sel`=010, `alu_src_b`=01, all others 0.
  - The first FETCH request is issued in the cycle `reset_n` is high.
- Reset mid-instruction abandons the instruction. No write enable may glitch high during reset.
- Cycles per instruction with `mem_ready` held at 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- Each wait cycle (`mem_ready`=0) in FETCH, MEMRD or MEMWR adds one cycle.
- While waiting, `mem_req`, `iord`, `mem_we` and the address selects are held stable. `ir_we`, `pc_we` and `reg_we` stay 0.
- A memory access completes in the cycle where `mem_req`=1 and `mem_ready`=1. Each access lasts exactly one such cycle; there are no back-to-back accesses without a state change.
- `mem_ready` is ignored when `mem_req`=0.
- `illegal` is a single-cycle pulse, coincident with the DECODE or EXECUTE cycle that detects the fault.

## Test plan
- Reset and lw: `reset_n` low for 3 cycles, then release; run lw (100011) with `mem_ready`=1. Required: all enables 0 during reset; state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; `reg_we`=1, `mem_to_reg`=1 in cycle 5 only.
- R-type funct sweep: funct 100000, 100010, 100100, 100101, 101010 in EXECUTE. Required: `alu_sel` 010, 110, 000, 001, 111 in turn. Funct 000000 gives `alu_sel` 010 and a one-cycle `illegal` pulse, then ALUWB with `reg_dst`=1.
- beq both ways: `zero`=1 gives `pc_we`=1 with `pc_src`=01 in cycle 3; `zero`=0 gives `pc_we`=0. FETCH follows in both cases.
- Wait states: sw with `mem_ready`=0 for 2 cycles in FETCH and 3 in MEMWR. Required: total 9 cycles; `mem_req`, `iord`=1 and `mem_we`=1 held stable through MEMWR; `ir_we` pulses only on the ready cycle.
- Illegal opcode and async reset: opcode 111111 gives `illegal`=1 in DECODE and a return to FETCH. Separately, assert `reset_n` low mid-MEMRD. Required: state is FETCH before the next edge and `mem_req`=0 immediately.
